alu_pipe: RTL and testbench

- Parametrised, pipelined integer ALU functional unit for the out-of-order core. Non-branch, non-multiply integer ops only.
- Accepts one op per cycle from the issue stage via valid/ready and carries the destination PRF tag and branch mask through STAGES pipeline registers.
- Presents its result to the CDB arbiter; holds the result until granted.
- Kills in-flight ops on branch mispredict squash and clears mask bits on correct resolution.

---
 rtl/alu_pipe_pkg.sv | 39 +++
 rtl/alu_pipe_core.sv | 59 +++++
 rtl/alu_pipe.sv | 116 +++++++++++
 tb/tb_alu_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode, width and packet definitions for the pipelined
// integer ALU functional unit.
package alu_pipe_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int TAG_W_DEF = 6;
  localparam int BRM_W_DEF = 4;

  typedef enum logic [4:0] {
    ALU_ADDQ   = 5'd0,
    ALU_SUBQ   = 5'd1,
    ALU_AND    = 5'd2,
    ALU_BIC    = 5'd3,
    ALU_BIS    = 5'd4,
    ALU_ORNOT  = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_EQV    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SLL    = 5'd9,
    ALU_SRA    = 5'd10,
    ALU_CMPULT = 5'd11,
    ALU_CMPEQ  = 5'd12,
    ALU_CMPULE = 5'd13,
    ALU_CMPLT  = 5'd14,
    ALU_CMPLE  = 5'd15,
    ALU_MIN    = 5'd16,
    ALU_MAX    = 5'd17,
    ALU_MINU   = 5'd18,
    ALU_MAXU   = 5'd19
  } alu_func_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  result;
    logic [TAG_W_DEF-1:0] tag;
    logic [BRM_W_DEF-1:0] brmask;
    logic                 illegal;
  } alu_pkt_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational integer datapath: func/opa/opb to result and
// an illegal flag for unassigned opcodes.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      func_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign shamt = opb_i[SH_W-1:0];
  assign lt_s  = $signed(opa_i) < $signed(opb_i);
  assign lt_u  = opa_i < opb_i;
  assign eq    = opa_i == opb_i;

  function automatic logic [XLEN-1:0] flag(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (func_i)
      ALU_ADDQ:   result_o = opa_i + opb_i;
      ALU_SUBQ:   result_o = opa_i - opb_i;
      ALU_AND:    result_o = opa_i & opb_i;
      ALU_BIC:    result_o = opa_i & ~opb_i;
      ALU_BIS:    result_o = opa_i | opb_i;
      ALU_ORNOT:  result_o = opa_i | ~opb_i;
      ALU_XOR:    result_o = opa_i ^ opb_i;
      ALU_EQV:    result_o = ~(opa_i ^ opb_i);
      ALU_SRL:    result_o = opa_i >> shamt;
      ALU_SLL:    result_o = opa_i << shamt;
      ALU_SRA:    result_o = $signed(opa_i) >>> shamt;
      ALU_CMPULT: result_o = flag(lt_u);
      ALU_CMPEQ:  result_o = flag(eq);
      ALU_CMPULE: result_o = flag(lt_u | eq);
      ALU_CMPLT:  result_o = flag(lt_s);
      ALU_CMPLE:  result_o = flag(lt_s | eq);
      ALU_MIN:    result_o = lt_s ? opa_i : opb_i;
      ALU_MAX:    result_o = lt_s ? opb_i : opa_i;
      ALU_MINU:   result_o = lt_u ? opa_i : opb_i;
      ALU_MAXU:   result_o = lt_u ? opb_i : opa_i;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU unit: computes at entry, carries tag and branch
// mask through STAGES registers, holds the tail until CDB grant.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int STAGES = 2,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int BRM_W  = BRM_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [XLEN-1:0]  opa_i,
  input  logic [XLEN-1:0]  opb_i,
  input  logic [4:0]       func_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [BRM_W-1:0] brmask_i,
  input  logic             br_resolve_i,
  input  logic             br_squash_i,
  input  logic [BRM_W-1:0] br_bit_i,
  input  logic             cdb_grant_i,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam int TAIL = STAGES - 1;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [BRM_W-1:0] brmask;
    logic             illegal;
  } pkt_t;

  logic [XLEN-1:0]   alu_res;
  logic              alu_ill;
  logic              accept;
  logic              down;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  pkt_t              src_pkt [STAGES];
  pkt_t              pkt_q   [STAGES];
  pkt_t              pkt_d   [STAGES];

  alu_core #(
    .XLEN(XLEN)
  ) u_core (
    .func_i   (func_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .result_o (alu_res),
    .illegal_o(alu_ill)
  );

  // A stage loads when it is empty or its successor loads.
  always_comb begin
    load = '0;
    down = cdb_grant_i;
    for (int k = TAIL; k >= 0; k--) begin
      down    = !vld_q[k] || down;
      load[k] = down;
    end
  end

  assign issue_ready_o = load[0];
  assign accept        = issue_valid_i && load[0];

  always_comb begin
    src_vld    = '0;
    src_vld[0] = accept;
    src_pkt[0] = '{alu_res, tag_i, brmask_i, alu_ill};
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_pkt[k] = pkt_q[k-1];
    end
  end

  // Squash wins over resolve; both act on whatever lands in a stage.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      pkt_d[k] = pkt_q[k];
      if (load[k]) begin
        vld_d[k] = src_vld[k];
        if (src_vld[k]) pkt_d[k] = src_pkt[k];
      end
      if (br_squash_i) begin
        if (|(pkt_d[k].brmask & br_bit_i)) vld_d[k] = 1'b0;
      end else if (br_resolve_i) begin
        pkt_d[k].brmask = pkt_d[k].brmask & ~br_bit_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) pkt_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) pkt_q[k] <= pkt_d[k];
    end
  end

  assign done_o    = vld_q[TAIL];
  assign result_o  = pkt_q[TAIL].result;
  assign tag_o     = pkt_q[TAIL].tag;
  assign illegal_o = vld_q[TAIL] & pkt_q[TAIL].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic
// against an in-order queue reference model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int ST = 2;

  typedef struct {
    logic [63:0] r;
    logic [5:0]  t;
    logic        il;
    logic [3:0]  m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ir, res, sq, gnt, done, ill;
  logic [63:0] a, b, ro;
  logic [4:0]  fn;
  logic [5:0]  tg, to;
  logic [3:0]  bm, bb;

  logic        iv2, ir2, res2, sq2, gnt2, done2, ill2;
  logic [31:0] a2, b2, ro2;
  logic [4:0]  fn2;
  logic [5:0]  tg2, to2;
  logic [3:0]  bm2, bb2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(6), .BRM_W(4)) u_dut (
    .clock(clk), .reset(rst),
    .issue_valid_i(iv), .issue_ready_o(ir),
    .opa_i(a), .opb_i(b), .func_i(fn), .tag_i(tg), .brmask_i(bm),
    .br_resolve_i(res), .br_squash_i(sq), .br_bit_i(bb),
    .cdb_grant_i(gnt), .done_o(done), .result_o(ro), .tag_o(to),
    .illegal_o(ill)
  );

  alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(6), .BRM_W(4)) u_dut32 (
    .clock(clk), .reset(rst),
    .issue_valid_i(iv2), .issue_ready_o(ir2),
    .opa_i(a2), .opb_i(b2), .func_i(fn2), .tag_i(tg2), .brmask_i(bm2),
    .br_resolve_i(res2), .br_squash_i(sq2), .br_bit_i(bb2),
    .cdb_grant_i(gnt2), .done_o(done2), .result_o(ro2), .tag_o(to2),
    .illegal_o(ill2)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns {illegal, result} from the architectural op definitions.
  function automatic logic [64:0] ref_alu(input logic [4:0] f,
                                          input logic [63:0] x,
                                          input logic [63:0] y);
    longint sx, sy;
    int sh;
    logic [63:0] r;
    sx = x;
    sy = y;
    sh = int'(y[5:0]);
    r = 64'd0;
    case (f)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x & y;
      5'd3:  r = x & ~y;
      5'd4:  r = x | y;
      5'd5:  r = x | ~y;
      5'd6:  r = x ^ y;
      5'd7:  r = ~(x ^ y);
      5'd8:  r = x >> sh;
      5'd9:  r = x << sh;
      5'd10: r = sx >>> sh;
      5'd11: r = (x < y) ? 64'd1 : 64'd0;
      5'd12: r = (x == y) ? 64'd1 : 64'd0;
      5'd13: r = (x <= y) ? 64'd1 : 64'd0;
      5'd14: r = (sx < sy) ? 64'd1 : 64'd0;
      5'd15: r = (sx <= sy) ? 64'd1 : 64'd0;
      5'd16: r = (sx < sy) ? x : y;
      5'd17: r = (sx > sy) ? x : y;
      5'd18: r = (x < y) ? x : y;
      5'd19: r = (x > y) ? x : y;
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, r};
  endfunction

  task automatic idle();
    iv = 0; a = '0; b = '0; fn = '0; tg = '0; bm = '0;
    res = 0; sq = 0; bb = '0; gnt = 1;
    iv2 = 0; a2 = '0; b2 = '0; fn2 = '0; tg2 = '0; bm2 = '0;
    res2 = 0; sq2 = 0; bb2 = '0; gnt2 = 1;
  endtask

  // Issues one op with grant high and waits (bounded) for its done.
  task automatic run_op(input logic [4:0] f, input logic [63:0] x,
                        input logic [63:0] y, input logic [5:0] t,
                        output logic [63:0] r, output logic il,
                        output logic [5:0] rt, output int lat);
    iv = 1; fn = f; a = x; b = y; tg = t; bm = '0; gnt = 1;
    lat = -1; r = '0; il = 0; rt = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      iv = 0;
      if (done) begin
        r = ro; il = ill; rt = to; lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (ill !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", ill); end
    n_chk++; if (ro !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", ro); end
    n_chk++; if (to !== 6'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", to); end
    n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ir); end
    n_chk++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done32 got %b want 0", done2); end
    n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL reset_ready32 got %b want 1", ir2); end
  endtask

  task automatic test_add_latency();
    iv = 1; fn = 5'd0; a = 64'd5; b = 64'd7; tg = 6'd3; bm = '0; gnt = 1;
    @(negedge clk);
    iv = 0;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_early_done got %b want 0", done); end
    @(negedge clk);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done got %b want 1", done); end
    n_chk++; if (ro !== 64'd12) begin n_fail++; $display("FAIL add_result got %0d want 12", ro); end
    n_chk++; if (to !== 6'd3) begin n_fail++; $display("FAIL add_tag got %0d want 3", to); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] er [6];
    logic [5:0]  et [6];
    logic [64:0] rr;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        n_chk++;
        if (done !== 1'b1 || ro !== er[c-2] || to !== et[c-2]) begin
          n_fail++;
          $display("FAIL b2b_%0d got done=%b res=%h tag=%0d want 1 %h %0d",
                   c - 2, done, ro, to, er[c-2], et[c-2]);
        end
      end
      if (c < 6) begin
        iv = 1; fn = 5'($urandom_range(0, 19));
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        tg = 6'(40 + c); bm = '0; gnt = 1;
        rr = ref_alu(fn, a, b);
        er[c] = rr[63:0]; et[c] = tg;
        n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ir); end
      end else begin
        iv = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ops();
    logic [4:0]  tf [9];
    logic [63:0] ta [9];
    logic [63:0] tb [9];
    logic [63:0] te [9];
    logic [63:0] r;
    logic        il;
    logic [5:0]  rt;
    int          lat;
    tf[0] = 5'd10; ta[0] = 64'h8000_0000_0000_0000; tb[0] = 64'd63; te[0] = '1;
    tf[1] = 5'd10; ta[1] = 64'h8000_0000_0000_1234; tb[1] = 64'd0;  te[1] = 64'h8000_0000_0000_1234;
    tf[2] = 5'd14; ta[2] = '1;     tb[2] = 64'd1;  te[2] = 64'd1;
    tf[3] = 5'd11; ta[3] = '1;     tb[3] = 64'd1;  te[3] = 64'd0;
    tf[4] = 5'd18; ta[4] = 64'd3;  tb[4] = '1;     te[4] = 64'd3;
    tf[5] = 5'd0;  ta[5] = '1;     tb[5] = 64'd1;  te[5] = 64'd0;
    tf[6] = 5'd9;  ta[6] = 64'd1;  tb[6] = 64'd65; te[6] = 64'd2;
    tf[7] = 5'd17; ta[7] = 64'hFFFF_FFFF_FFFF_FFFB; tb[7] = 64'd3; te[7] = 64'd3;
    tf[8] = 5'd7;  ta[8] = 64'h00FF; tb[8] = 64'h0F0F; te[8] = 64'hFFFF_FFFF_FFFF_F00F;
    for (int i = 0; i < 9; i++) begin
      run_op(tf[i], ta[i], tb[i], 6'(i + 1), r, il, rt, lat);
      n_chk++;
      if (lat != 2 || r !== te[i] || il !== 1'b0 || rt !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL op_%0d got lat=%0d res=%h ill=%b tag=%0d want 2 %h 0 %0d",
                 i, lat, r, il, rt, te[i], i + 1);
      end
    end
  endtask

  task automatic test_illegal();
    logic [63:0] r;
    logic        il;
    logic [5:0]  rt;
    int          lat;
    run_op(5'd31, 64'd9, 64'd9, 6'd17, r, il, rt, lat);
    n_chk++; if (il !== 1'b1 || r !== 64'd0 || rt !== 6'd17) begin
      n_fail++; $display("FAIL illegal31 got ill=%b res=%h tag=%0d want 1 0 17", il, r, rt); end
    run_op(5'd20, 64'd9, 64'd9, 6'd18, r, il, rt, lat);
    n_chk++; if (il !== 1'b1 || r !== 64'd0) begin
      n_fail++; $display("FAIL illegal20 got ill=%b res=%h want 1 0", il, r); end
    @(negedge clk);
    n_chk++; if (ill !== 1'b0) begin n_fail++; $display("FAIL illegal_idle got %b want 0", ill); end
  endtask

  task automatic test_stall();
    int acc = 0;
    logic [63:0] hr;
    logic [5:0]  ht;
    logic [5:0]  got [$];
    logic [63:0] gr [$];
    gnt = 0;
    for (int c = 0; c < 4; c++) begin
      iv = 1; fn = 5'd0; a = 64'(100 + acc); b = '0; tg = 6'(10 + acc); bm = '0;
      #1;
      if (ir) acc++;
      @(negedge clk);
    end
    iv = 0;
    n_chk++; if (acc != 2) begin n_fail++; $display("FAIL stall_accepts got %0d want 2", acc); end
    n_chk++; if (ir !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", ir); end
    hr = ro; ht = to;
    n_chk++; if (done !== 1'b1 || ht !== 6'd10) begin
      n_fail++; $display("FAIL stall_head got done=%b tag=%0d want 1 10", done, ht); end
    repeat (3) @(negedge clk);
    n_chk++; if (ro !== 64'd100 || to !== 6'd10 || ro !== hr) begin
      n_fail++; $display("FAIL stall_hold got res=%0d tag=%0d want 100 10", ro, to); end
    for (int c = 0; c < 12; c++) begin
      gnt = 1;
      if (acc < 3) begin
        iv = 1; a = 64'(100 + acc); tg = 6'(10 + acc);
      end else iv = 0;
      #1;
      if (iv && ir) acc++;
      if (done) begin got.push_back(to); gr.push_back(ro); end
      @(negedge clk);
    end
    iv = 0;
    n_chk++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL stall_drain_count got %0d want 3", got.size());
    end else if (got[0] !== 6'd10 || got[1] !== 6'd11 || got[2] !== 6'd12 ||
                 gr[2] !== 64'd102) begin
      n_fail++;
      $display("FAIL stall_order got %0d %0d %0d res=%0d want 10 11 12 res=102",
               got[0], got[1], got[2], gr[2]);
    end
  endtask

  task automatic test_squash();
    int nd;
    gnt = 0; iv = 1; fn = 5'd0; a = 64'd1; b = 64'd1; tg = 6'd20; bm = 4'b0010;
    @(negedge clk);
    tg = 6'd21;
    @(negedge clk);
    iv = 0;
    n_chk++; if (done !== 1'b1 || to !== 6'd20) begin
      n_fail++; $display("FAIL sq_setup got done=%b tag=%0d want 1 20", done, to); end
    sq = 1; bb = 4'b0010;
    @(negedge clk);
    sq = 0; bb = '0;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL sq_tail_kill got %b want 0", done); end
    nd = 0; gnt = 1;
    repeat (4) begin @(negedge clk); if (done) nd++; end
    n_chk++; if (nd != 0) begin n_fail++; $display("FAIL sq_both_gone got %0d dones want 0", nd); end
    gnt = 0; iv = 1; tg = 6'd22; bm = 4'b0100;
    @(negedge clk);
    tg = 6'd23; bm = 4'b0010;
    @(negedge clk);
    iv = 0; sq = 1; bb = 4'b0010;
    @(negedge clk);
    sq = 0; bb = '0;
    n_chk++; if (done !== 1'b1 || to !== 6'd22) begin
      n_fail++; $display("FAIL sq_survivor got done=%b tag=%0d want 1 22", done, to); end
    gnt = 1; nd = 0;
    repeat (4) begin @(negedge clk); if (done) nd++; end
    n_chk++; if (nd != 0) begin n_fail++; $display("FAIL sq_victim_gone got %0d dones want 0", nd); end
  endtask

  task automatic test_resolve();
    gnt = 0; iv = 1; fn = 5'd0; a = 64'd2; b = 64'd3; tg = 6'd30; bm = 4'b0010;
    @(negedge clk);
    iv = 0; res = 1; bb = 4'b0010;
    @(negedge clk);
    res = 0; sq = 1;
    @(negedge clk);
    sq = 0; bb = '0;
    n_chk++; if (done !== 1'b1 || to !== 6'd30 || ro !== 64'd5) begin
      n_fail++; $display("FAIL resolve_survive got done=%b tag=%0d res=%0d want 1 30 5", done, to, ro); end
    gnt = 1;
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL resolve_drain got %b want 0", done); end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    exp_t nq [$];
    logic [64:0] rr;
    int nrun = 600;
    for (int c = 0; c < nrun + 20; c++) begin
      if (c < nrun) begin
        iv = ($urandom_range(0, 3) != 0);
        fn = 5'($urandom_range(0, 21));
        a = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0: b = {$urandom, $urandom};
          1: b = 64'($urandom_range(0, 70));
          default: b = a;
        endcase
        tg = 6'($urandom); bm = 4'($urandom);
        gnt = ($urandom_range(0, 3) != 0);
        sq = ($urandom_range(0, 15) == 0);
        res = ($urandom_range(0, 7) == 0);
        bb = '0; bb[$urandom_range(0, 3)] = 1'b1;
      end else begin
        iv = 0; sq = 0; res = 0; gnt = 1; bb = '0;
      end
      #1;
      if (done && q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_spurious_done cyc=%0d tag=%0d want no result", c, to);
      end else if (done && gnt && !(sq && |(q[0].m & bb))) begin
        e = q.pop_front();
        n_chk++;
        if (ro !== e.r || to !== e.t || ill !== e.il) begin
          n_fail++;
          $display("FAIL rnd_result cyc=%0d got %h/%0d/%b want %h/%0d/%b",
                   c, ro, to, ill, e.r, e.t, e.il);
        end
      end
      if (sq) begin
        nq = {};
        foreach (q[i]) if (!(|(q[i].m & bb))) nq.push_back(q[i]);
        q = nq;
      end else if (res) begin
        foreach (q[i]) q[i].m = q[i].m & ~bb;
      end
      if (iv && ir) begin
        rr = ref_alu(fn, a, b);
        e.r = rr[63:0]; e.il = rr[64]; e.t = tg; e.m = bm;
        if (sq && |(bm & bb)) begin
        end else begin
          if (!sq && res) e.m = e.m & ~bb;
          q.push_back(e);
        end
      end
      if (q.size() > ST) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_occupancy cyc=%0d got %0d in flight want <= %0d", c, q.size(), ST);
      end
      @(negedge clk);
    end
    n_chk++; if (q.size() != 0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain got %0d pending done=%b want 0 0", q.size(), done); end
  endtask

  task automatic test_xlen32_and_reset();
    iv2 = 1; fn2 = 5'd1; a2 = 32'd0; b2 = 32'd1; tg2 = 6'd7; gnt2 = 1;
    @(negedge clk);
    iv2 = 0;
    n_chk++; if (done2 !== 1'b1 || ro2 !== 32'hFFFF_FFFF || to2 !== 6'd7) begin
      n_fail++; $display("FAIL x32_sub got done=%b res=%h tag=%0d want 1 ffffffff 7", done2, ro2, to2); end
    gnt2 = 0; iv2 = 1; gnt = 0; iv = 1; fn = 5'd0; bm = '0;
    @(negedge clk);
    @(negedge clk);
    iv = 0; iv2 = 0;
    n_chk++; if (done !== 1'b1 || done2 !== 1'b1 || ir !== 1'b0) begin
      n_fail++; $display("FAIL full_before_reset got done=%b done32=%b ready=%b want 1 1 0", done, done2, ir); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_chk++; if (done !== 1'b0 || done2 !== 1'b0 || ill !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got done=%b done32=%b ill=%b want 0 0 0", done, done2, ill); end
    gnt = 1; gnt2 = 1;
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL after_reset got done=%b ready=%b want 0 1", done, ir); end
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_ops();
    test_illegal();
    test_stall();
    test_squash();
    test_resolve();
    test_random();
    test_xlen32_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
